// File: rtl/wb8_pkg.sv
// -----------------------------------------------------------------------------
// wb8_pkg
// Shared definitions for the 8-bit Wishbone byte master:
//   - size_e   : CPU-side access size codes (byte / halfword / word / reserved)
//   - state_e  : master FSM state encoding
//   - size_to_count() : number of single-byte bus cycles for a size code
// -----------------------------------------------------------------------------
package wb8_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2,
        SIZE_RSVD = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_e;

    // Byte count for a size code; the reserved code is handled as a word.
    function automatic logic [2:0] size_to_count(input logic [1:0] size);
        logic [2:0] cnt;
        case (size)
            SIZE_BYTE: cnt = 3'd1;
            SIZE_HALF: cnt = 3'd2;
            SIZE_WORD: cnt = 3'd4;
            default:   cnt = 3'd4;
        endcase
        return cnt;
    endfunction

endpackage

// File: rtl/wb8_timeout_ctr.sv
// -----------------------------------------------------------------------------
// wb8_timeout_ctr
// Counts strobe cycles that go unacknowledged and flags expiry on the cycle in
// which the LIMIT-th unacknowledged strobe cycle is being sampled, so the
// master can abort at that same edge.
// Ports:
//   i_clk      clock, rising edge
//   i_rst_n    synchronous active-low reset
//   i_active   master is in its strobe (XFER) state; counter held at 0 otherwise
//   i_ack      Wishbone acknowledge
//   o_expired  abort request (combinational, consumed by the master FSM)
// -----------------------------------------------------------------------------
module wb8_timeout_ctr #(
    parameter int LIMIT = 15
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_active,
    input  logic i_ack,
    output logic o_expired
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] r_cnt;

    // Wait counter: cleared outside XFER (so every XFER entry restarts it),
    // advanced on each XFER cycle without ACK.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (!i_active) begin
            r_cnt <= '0;
        end else if (!i_ack) begin
            r_cnt <= r_cnt + CW'(1'b1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

    // The current cycle is the LIMIT-th one without ACK when LIMIT-1 have
    // already been counted.
    assign o_expired = i_active && !i_ack && (r_cnt == CW'(LIMIT - 1));

endmodule

// File: rtl/wb8_byte_master.sv
// -----------------------------------------------------------------------------
// wb8_byte_master
// Wishbone initiator for an 8-bit bus. A single byte/halfword/word load or
// store from the CPU side is split into little-endian single-byte Wishbone
// cycles; load bytes are reassembled into a zero-extended 32-bit result.
// Each byte cycle is followed by one strobe-low GAP cycle because the
// responder registers ACK from STB and would otherwise hand back a stale ACK.
//
// Optional build macro: WB8_TIMEOUT_EN -- abort a byte cycle that is not
// acknowledged within TIMEOUT_CYCLES strobe cycles and report it on O_err.
// Without the macro the master waits indefinitely and O_err stays 0.
//
// Ports:
//   CLK_I, RST_I           clock; synchronous active-low reset
//   I_req/I_we/I_size/I_addr/I_wdata   CPU request (sampled only in IDLE)
//   O_busy, O_done, O_rdata, O_err     CPU status / result
//   CYC_O, STB_O, WE_O, ADR_O, DAT_O   Wishbone master outputs
//   DAT_I, ACK_I                       Wishbone master inputs
// -----------------------------------------------------------------------------
module wb8_byte_master
    import wb8_pkg::*;
#(
    parameter int ADR_WIDTH      = 17,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                 CLK_I,
    input  logic                 RST_I,
    input  logic                 I_req,
    input  logic                 I_we,
    input  logic [1:0]           I_size,
    input  logic [ADR_WIDTH-1:0] I_addr,
    input  logic [31:0]          I_wdata,
    output logic                 O_busy,
    output logic                 O_done,
    output logic [31:0]          O_rdata,
    output logic                 O_err,
    output logic                 CYC_O,
    output logic                 STB_O,
    output logic                 WE_O,
    output logic [ADR_WIDTH-1:0] ADR_O,
    output logic [7:0]           DAT_O,
    input  logic [7:0]           DAT_I,
    input  logic                 ACK_I
);

    state_e                 r_state;
    state_e                 w_state;
    logic [ADR_WIDTH-1:0]   r_base;
    logic [ADR_WIDTH-1:0]   w_base;
    logic [31:0]            r_wdata;
    logic [31:0]            w_wdata;
    logic [1:0]             r_idx;
    logic [1:0]             w_idx;
    logic [1:0]             r_last;
    logic [1:0]             w_last;
    logic                   w_cyc;
    logic                   w_stb;
    logic                   w_we;
    logic [ADR_WIDTH-1:0]   w_adr;
    logic [7:0]             w_dat;
    logic                   w_busy;
    logic                   w_done;
    logic [31:0]            w_rdata;
    logic                   w_err;
    logic                   w_timeout;

`ifdef WB8_TIMEOUT_EN
    wb8_timeout_ctr #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .i_clk     (CLK_I),
        .i_rst_n   (RST_I),
        .i_active  (r_state == XFER),
        .i_ack     (ACK_I),
        .o_expired (w_timeout)
    );
`else
    logic w_unused_timeout_cfg;

    assign w_timeout            = 1'b0;
    assign w_unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
`endif

    // Next-state and next-output logic; every register holds unless changed.
    always_comb begin
        w_state = r_state;
        w_base  = r_base;
        w_wdata = r_wdata;
        w_idx   = r_idx;
        w_last  = r_last;
        w_cyc   = CYC_O;
        w_stb   = STB_O;
        w_we    = WE_O;
        w_adr   = ADR_O;
        w_dat   = DAT_O;
        w_busy  = O_busy;
        w_done  = 1'b0;
        w_rdata = O_rdata;
        w_err   = O_err;

        case (r_state)
            IDLE: begin
                if (I_req) begin
                    w_state = XFER;
                    w_base  = I_addr;
                    w_wdata = I_wdata;
                    w_idx   = 2'd0;
                    w_last  = 2'(size_to_count(I_size) - 3'd1);
                    w_cyc   = 1'b1;
                    w_stb   = 1'b1;
                    w_we    = I_we;
                    w_adr   = I_addr;
                    w_dat   = I_wdata[7:0];
                    w_busy  = 1'b1;
                    w_rdata = 32'h0000_0000;
                    w_err   = 1'b0;
                end else begin
                    w_busy  = 1'b0;
                end
            end

            XFER: begin
                if (ACK_I) begin
                    if (!WE_O) begin
                        w_rdata[{r_idx, 3'b000} +: 8] = DAT_I;
                    end else begin
                        w_rdata = O_rdata;
                    end
                    if (r_idx == r_last) begin
                        w_state = DONE;
                        w_cyc   = 1'b0;
                        w_stb   = 1'b0;
                        w_we    = 1'b0;
                        w_done  = 1'b1;
                    end else begin
                        w_state = GAP;
                        w_stb   = 1'b0;
                    end
                end else if (w_timeout) begin
                    // Abort: remaining bytes are skipped, partial load data kept.
                    w_state = DONE;
                    w_cyc   = 1'b0;
                    w_stb   = 1'b0;
                    w_we    = 1'b0;
                    w_done  = 1'b1;
                    w_err   = 1'b1;
                end else begin
                    w_state = XFER;
                end
            end

            GAP: begin
                // ACK_I is deliberately not looked at here: it is the stale
                // echo of the strobe that just completed.
                w_idx   = r_idx + 2'd1;
                w_adr   = r_base + {{(ADR_WIDTH-2){1'b0}}, w_idx};
                w_dat   = r_wdata[{w_idx, 3'b000} +: 8];
                w_stb   = 1'b1;
                w_state = XFER;
            end

            DONE: begin
                w_state = IDLE;
                w_busy  = 1'b0;
            end

            default: begin
                w_state = IDLE;
                w_cyc   = 1'b0;
                w_stb   = 1'b0;
                w_we    = 1'b0;
                w_busy  = 1'b0;
            end
        endcase
    end

    // State and registered-output update; reset releases the bus at once.
    always_ff @(posedge CLK_I) begin
        if (!RST_I) begin
            r_state <= IDLE;
            r_base  <= '0;
            r_wdata <= 32'h0000_0000;
            r_idx   <= 2'd0;
            r_last  <= 2'd0;
            CYC_O   <= 1'b0;
            STB_O   <= 1'b0;
            WE_O    <= 1'b0;
            ADR_O   <= '0;
            DAT_O   <= 8'h00;
            O_busy  <= 1'b0;
            O_done  <= 1'b0;
            O_rdata <= 32'h0000_0000;
            O_err   <= 1'b0;
        end else begin
            r_state <= w_state;
            r_base  <= w_base;
            r_wdata <= w_wdata;
            r_idx   <= w_idx;
            r_last  <= w_last;
            CYC_O   <= w_cyc;
            STB_O   <= w_stb;
            WE_O    <= w_we;
            ADR_O   <= w_adr;
            DAT_O   <= w_dat;
            O_busy  <= w_busy;
            O_done  <= w_done;
            O_rdata <= w_rdata;
            O_err   <= w_err;
        end
    end

endmodule

// File: doc/wb8_byte_master.md
Name: wb8_byte_master

Overview:
- Wishbone initiator for the 8-bit memory bus. It drives the byte-wide SRAM responder and any other 8-bit Wishbone slave.
- Accepts one byte, halfword or word load/store from the CPU-side request port. Splits it into sequential single-byte Wishbone cycles, little-endian, and reassembles read data into a 32-bit result.
- Sits between the CPU load/store unit and the 8-bit bus.

Parameters:
ADR_WIDTH, 17, Wishbone byte-address width.
TIMEOUT_CYCLES, 15, STB-high cycles without ACK before abort (used only with WB8_TIMEOUT_EN).

Ports:
CLK_I  in  1  clock; all logic on rising edge.
RST_I  in  1  reset, synchronous, active-low.
I_req  in  1  request strobe; sampled only when idle.
I_we  in  1  1 = store, 0 = load.
I_size  in  2  0 = byte, 1 = halfword, 2 = word, 3 = reserved (treated as word).
I_addr  in  ADR_WIDTH  byte address of the lowest byte.
I_wdata  in  32  store data; byte k goes to I_addr+k.
O_busy  out  1  high from acceptance until the cycle after O_done.
O_done  out  1  one-cycle completion pulse.
O_rdata  out  32  load result, zero-extended; valid while O_done is high, held until the next acceptance.
O_err  out  1  timeout abort flag, qualified by O_done.
CYC_O  out  1  Wishbone cycle.
STB_O  out  1  Wishbone strobe.
WE_O  out  1  Wishbone write enable.
ADR_O  out  ADR_WIDTH  Wishbone byte address.
DAT_O  out  8  Wishbone write data.
DAT_I  in  8  Wishbone read data.
ACK_I  in  1  Wishbone acknowledge.

Behaviour:
- All outputs are registered.
- Reset (RST_I=0 at an edge): state IDLE; CYC_O, STB_O, WE_O, O_busy, O_done and O_err are 0; ADR_O, DAT_O and O_rdata are 0.
- Reset mid-transfer aborts at once: no O_done pulse, and the bus is released at that same edge.
- States: IDLE, XFER, GAP, DONE.
- IDLE:
  - I_req=1 at an edge → latch addr, wdata, we and size.
  - Byte count N = 1, 2 or 4; index idx=0; O_rdata cleared.
  - → XFER with CYC_O=1, STB_O=1, WE_O=I_we, ADR_O=I_addr, DAT_O=I_wdata[7:0], O_busy=1.
- XFER:
  - Hold STB_O, ADR_O and DAT_O until ACK_I is sampled high.
  - On ACK during a load, store DAT_I into O_rdata byte idx.
  - If idx==N-1 → DONE; otherwise → GAP.
- GAP:
  - STB_O=0, CYC_O stays 1. Ignore ACK_I.
  - Gap is mandatory: the responder registers ACK from STB, so a held strobe produces a stale ACK. Any ACK while STB_O=0 is always ignored.
  - Next edge: idx+1, ADR_O = base+idx+1 (wraps modulo 2^ADR_WIDTH), DAT_O = next byte, STB_O=1 → XFER.
- DONE:
  - CYC_O=0, STB_O=0, O_done=1 for exactly one cycle → IDLE.
  - O_busy drops in the following cycle.
  - I_req asserted in DONE is ignored; it is accepted in IDLE.
- Misaligned addresses are legal; no alignment check.
- Stores: the byte repeated while the responder's ACK is in flight is a benign idempotent re-write.
- Timing with a 1-cycle-ACK slave: O_done is high 3N-1 cycles after the acceptance edge (byte: 2, halfword: 5, word: 11).
- I_req while O_busy is ignored; no queueing.

Optional Feature:
- Macro WB8_TIMEOUT_EN.
- Defined:
  - A counter clears on every entry to XFER and increments on each XFER cycle without ACK.
  - On reaching TIMEOUT_CYCLES: → DONE with O_err=1, STB_O and CYC_O drop, remaining bytes skipped, O_rdata holds the bytes received so far.
  - O_err is cleared on the next acceptance.
- Undefined:
  - No counter; XFER waits indefinitely.
  - O_err is tied to 0.

Decomposition:
- Package wb8_pkg:
  - Size codes SIZE_BYTE, SIZE_HALF, SIZE_WORD.
  - State encoding IDLE, XFER, GAP, DONE.
  - Function size_to_count.
- Optional sub-module wb8_timeout_ctr (counter plus compare), instantiated only under WB8_TIMEOUT_EN.
- Everything else is one FSM module.

Test Plan:
- Word store, addr 0x00003, wdata 0xA1B2C3D4, 1-cycle-ACK slave model → bytes D4, C3, B2, A1 written to 0x00003..0x00006; WE_O=1 on every strobe; one STB-low cycle between bytes; O_done 11 cycles after accept.
- Word load, memory 0x10..0x13 = 11 22 33 44 → O_rdata=0x44332211 with O_done; CYC_O low in the DONE cycle.
- Halfword load at 0x1FFFF (ADR_WIDTH=17) → second access at ADR_O=0x00000 (wrap); O_rdata=0x0000_{[0x00000],[0x1FFFF]}.
- Byte load, then I_req held high continuously → second request accepted only after IDLE is re-entered; stale ACK during GAP/DONE never corrupts O_rdata.
- Reset asserted during the third byte of a word store → next edge CYC_O=STB_O=0, no O_done; a subsequent byte store completes normally in 2 cycles.
- With WB8_TIMEOUT_EN, slave never ACKs → after 15 strobe cycles O_done=1, O_err=1, CYC_O=0; next good request clears O_err.
